// File: rtl/dst_pkg.sv
// dst_pkg -- shared definitions for the dual_stream_tx slice.
//   GAP_W           : width of the inter-beat gap counter (GAP range 0..15)
//   MARKER1/MARKER2 : end-of-burst marker bytes for channel 1 / channel 2
//   eng_state_t     : per-channel engine state; S_MARK exists only when
//                     MARKER_INSERT_EN is defined
package dst_pkg;

    localparam int         GAP_W   = 4;
    localparam logic [7:0] MARKER1 = 8'hAA;
    localparam logic [7:0] MARKER2 = 8'h55;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
`ifdef MARKER_INSERT_EN
        S_GAP  = 2'd2,
        S_MARK = 2'd3
`else
        S_GAP  = 2'd2
`endif
    } eng_state_t;

endpackage

// File: rtl/dual_stream_tx_if.sv
// dual_stream_tx_if -- command port and both beat channels of dual_stream_tx.
//   cmd_valid/cmd_ready/cmd_chan/cmd_start/cmd_len/cmd_incr : command handshake
//   flush                                                   : abort both channels
//   valid1/in1/busy1/done1, valid2/in2/busy2/done2          : channel outputs
// master = command source / beat sink, slave = the transmitter.
interface dual_stream_tx_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_chan;
    logic [7:0] cmd_start;
    logic [7:0] cmd_len;
    logic       cmd_incr;
    logic       flush;
    logic       valid1;
    logic       valid2;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       busy1;
    logic       busy2;
    logic       done1;
    logic       done2;

    modport master (
        output cmd_valid, cmd_chan, cmd_start, cmd_len, cmd_incr, flush,
        input  cmd_ready, valid1, valid2, in1, in2, busy1, busy2, done1, done2
    );

    modport slave (
        input  cmd_valid, cmd_chan, cmd_start, cmd_len, cmd_incr, flush,
        output cmd_ready, valid1, valid2, in1, in2, busy1, busy2, done1, done2
    );

endinterface

// File: rtl/dst_chan_engine.sv
// dst_chan_engine -- one channel burst engine: FSM, beat counter, data generator.
// Parameters: GAP (idle cycles between beats, 0..15), MARKER (end marker byte).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_flush      : abort to IDLE on the next edge without a done pulse
//   i_accept     : command accepted this cycle (only meaningful in IDLE)
//   i_start/i_len/i_incr : first byte, beat count (0 = 256), increment mode
//   o_valid/o_data : beat strobe and data (data holds while valid is low)
//   o_busy/o_done  : engine not IDLE / one-cycle burst-complete pulse
// Optional feature macro: MARKER_INSERT_EN appends a MARKER beat to every burst.
module dst_chan_engine
    import dst_pkg::*;
#(
    parameter int         GAP    = 0,
    parameter logic [7:0] MARKER = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_flush,
    input  logic       i_accept,
    input  logic [7:0] i_start,
    input  logic [7:0] i_len,
    input  logic       i_incr,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [GAP_W-1:0] GAP_M1 = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    eng_state_t       r_state, w_state;
    logic [7:0]       r_data,  w_data;
    logic [8:0]       r_left,  w_left;   // beats still to send, 1..256
    logic [GAP_W-1:0] r_gcnt,  w_gcnt;
    logic             r_incr,  w_incr;
    logic             r_done,  w_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_left  <= '0;
            r_gcnt  <= '0;
            r_incr  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_data  <= w_data;
            r_left  <= w_left;
            r_gcnt  <= w_gcnt;
            r_incr  <= w_incr;
            r_done  <= w_done;
        end
    end

    // r_data always holds the byte on the wire; it only changes on the edge
    // that enters SEND or MARK, so it is stable whenever valid is low.
    always_comb begin
        w_state = r_state;
        w_data  = r_data;
        w_left  = r_left;
        w_gcnt  = r_gcnt;
        w_incr  = r_incr;
        w_done  = 1'b0;
        if (i_flush) begin
            w_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_accept) begin
                        w_state = S_SEND;
                        w_data  = i_start;
                        w_left  = (i_len == 8'd0) ? 9'd256 : {1'b0, i_len};
                        w_incr  = i_incr;
                    end
                end
                S_SEND: begin
                    w_left = r_left - 9'd1;
                    if (r_left == 9'd1) begin
`ifdef MARKER_INSERT_EN
                        // r_left reaches 0 here; GAP uses that to pick MARK next
                        if (GAP > 0) begin
                            w_state = S_GAP;
                            w_gcnt  = GAP_M1;
                        end else begin
                            w_state = S_MARK;
                            w_data  = MARKER;
                        end
`else
                        w_state = S_IDLE;
                        w_done  = 1'b1;
`endif
                    end else if (GAP > 0) begin
                        w_state = S_GAP;
                        w_gcnt  = GAP_M1;
                    end else begin
                        w_data = r_data + {7'd0, r_incr};
                    end
                end
                S_GAP: begin
                    if (r_gcnt == '0) begin
`ifdef MARKER_INSERT_EN
                        if (r_left == 9'd0) begin
                            w_state = S_MARK;
                            w_data  = MARKER;
                        end else begin
                            w_state = S_SEND;
                            w_data  = r_data + {7'd0, r_incr};
                        end
`else
                        w_state = S_SEND;
                        w_data  = r_data + {7'd0, r_incr};
`endif
                    end else begin
                        w_gcnt = r_gcnt - 1'b1;
                    end
                end
`ifdef MARKER_INSERT_EN
                S_MARK: begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                end
`endif
                default: w_state = S_IDLE;
            endcase
        end
    end

`ifdef MARKER_INSERT_EN
    assign o_valid = (r_state == S_SEND) || (r_state == S_MARK);
`else
    assign o_valid = (r_state == S_SEND);
    // marker byte has no consumer when the marker beat is compiled out
    logic w_unused_marker;
    assign w_unused_marker = ^MARKER;
`endif
    assign o_data = r_data;
    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;

endmodule

// File: rtl/dual_stream_tx.sv
// dual_stream_tx -- two independent burst transmitters behind one command port.
// Parameter: GAP (idle cycles between beats on a channel, 0..15).
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : dual_stream_tx_if.slave (command handshake, flush, per-channel
//             valid/in/busy/done)
// Optional feature macro: MARKER_INSERT_EN ends every burst with a marker beat
// (channel 1: MARKER1, channel 2: MARKER2).
module dual_stream_tx
    import dst_pkg::*;
#(
    parameter int GAP = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    dual_stream_tx_if.slave        bus
);

    logic w_acc1;
    logic w_acc2;

    // flush blocks acceptance, so it wins over a simultaneous command
    assign bus.cmd_ready = !bus.flush && (bus.cmd_chan ? !bus.busy2 : !bus.busy1);
    assign w_acc1 = bus.cmd_valid && bus.cmd_ready && !bus.cmd_chan;
    assign w_acc2 = bus.cmd_valid && bus.cmd_ready &&  bus.cmd_chan;

    dst_chan_engine #(.GAP(GAP), .MARKER(MARKER1)) u_chan1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_flush  (bus.flush),
        .i_accept (w_acc1),
        .i_start  (bus.cmd_start),
        .i_len    (bus.cmd_len),
        .i_incr   (bus.cmd_incr),
        .o_valid  (bus.valid1),
        .o_data   (bus.in1),
        .o_busy   (bus.busy1),
        .o_done   (bus.done1)
    );

    dst_chan_engine #(.GAP(GAP), .MARKER(MARKER2)) u_chan2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_flush  (bus.flush),
        .i_accept (w_acc2),
        .i_start  (bus.cmd_start),
        .i_len    (bus.cmd_len),
        .i_incr   (bus.cmd_incr),
        .o_valid  (bus.valid2),
        .o_data   (bus.in2),
        .o_busy   (bus.busy2),
        .o_done   (bus.done2)
    );

endmodule

// File: tb/tb_dual_stream_tx.sv
// tb_dual_stream_tx -- scoreboard bench for dual_stream_tx.
// Two instances: dut0 with GAP=0, dut1 with GAP=2. Index i = 2*dut + channel.
// Works with and without MARKER_INSERT_EN.
module tb_dual_stream_tx;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset_n;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    beat_t      expq [4][$];
    int         doneq [4][$];
    logic [7:0] last_d [4];
    logic       mv [4];
    logic       mdn [4];
    logic       mb [4];
    logic [7:0] md [4];

    dual_stream_tx_if b0 ();
    dual_stream_tx_if b1 ();

    dual_stream_tx #(.GAP(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));
    dual_stream_tx #(.GAP(2)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mv[0] = b0.valid1;  assign md[0] = b0.in1;  assign mb[0] = b0.busy1;  assign mdn[0] = b0.done1;
    assign mv[1] = b0.valid2;  assign md[1] = b0.in2;  assign mb[1] = b0.busy2;  assign mdn[1] = b0.done2;
    assign mv[2] = b1.valid1;  assign md[2] = b1.in1;  assign mb[2] = b1.busy1;  assign mdn[2] = b1.done1;
    assign mv[3] = b1.valid2;  assign md[3] = b1.in2;  assign mb[3] = b1.busy2;  assign mdn[3] = b1.done2;

    // Monitor: every beat and done pulse must match the head of its queue.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            beat_t e;
            int    dc;
            if (!reset_n) last_d[i] = 8'h00;
            if (mv[i]) begin
                if (expq[i].size() == 0) begin
                    checks++;
                    assert (mv[i] === 1'b0) else begin
                        errors++;
                        $error("FAIL unexpected_beat ch%0d cyc=%0d data=%h got valid=%b required 0", i, cyc, md[i], mv[i]);
                    end
                end else begin
                    e = expq[i].pop_front();
                    checks++;
                    assert (md[i] === e.data) else begin
                        errors++;
                        $error("FAIL beat_data ch%0d cyc=%0d got %h required %h", i, cyc, md[i], e.data);
                    end
                    checks++;
                    assert (cyc === e.cyc) else begin
                        errors++;
                        $error("FAIL beat_cycle ch%0d data=%h got cyc %0d required %0d", i, md[i], cyc, e.cyc);
                    end
                end
                last_d[i] = md[i];
            end else begin
                checks++;
                assert (md[i] === last_d[i]) else begin
                    errors++;
                    $error("FAIL data_hold ch%0d cyc=%0d got %h required %h", i, cyc, md[i], last_d[i]);
                end
            end
            if (mdn[i]) begin
                if (doneq[i].size() == 0) begin
                    checks++;
                    assert (mdn[i] === 1'b0) else begin
                        errors++;
                        $error("FAIL unexpected_done ch%0d cyc=%0d got %b required 0", i, cyc, mdn[i]);
                    end
                end else begin
                    dc = doneq[i].pop_front();
                    checks++;
                    assert (cyc === dc) else begin
                        errors++;
                        $error("FAIL done_cycle ch%0d got %0d required %0d", i, cyc, dc);
                    end
                    checks++;
                    assert (mb[i] === 1'b0) else begin
                        errors++;
                        $error("FAIL busy_in_done ch%0d got %b required 0", i, mb[i]);
                    end
                end
            end
        end
    end

    task automatic drive(input int d, input bit v, input bit ch, input logic [7:0] st,
                         input logic [7:0] ln, input bit inc, input bit fl);
        if (d == 0) begin
            b0.cmd_valid = v; b0.cmd_chan = ch; b0.cmd_start = st;
            b0.cmd_len = ln;  b0.cmd_incr = inc; b0.flush = fl;
        end else begin
            b1.cmd_valid = v; b1.cmd_chan = ch; b1.cmd_start = st;
            b1.cmd_len = ln;  b1.cmd_incr = inc; b1.flush = fl;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? b0.cmd_ready : b1.cmd_ready;
    endfunction

    // Called at posedge+1; returns at the next posedge+1 with cmd_valid low.
    task automatic issue(input int d, input bit ch, input logic [7:0] st,
                         input logic [7:0] ln, input bit inc, output int dcyc);
        int    i, g, n, c0, last;
        beat_t e;
        i = 2 * d + int'(ch);
        g = (d == 0) ? 0 : 2;
        n = (ln == 8'd0) ? 256 : int'(ln);
        drive(d, 1'b1, ch, st, ln, inc, 1'b0);
        #1;
        checks++;
        assert (rdy(d) === 1'b1) else begin
            errors++;
            $error("FAIL cmd_ready dut%0d ch%0d got %b required 1", d, ch, rdy(d));
        end
        c0 = cyc;
        for (int k = 0; k < n; k++) begin
            e.cyc  = c0 + 1 + k * (g + 1);
            e.data = st + (inc ? 8'(k) : 8'd0);
            expq[i].push_back(e);
        end
        last = c0 + 1 + (n - 1) * (g + 1);
`ifdef MARKER_INSERT_EN
        last   = last + g + 1;
        e.cyc  = last;
        e.data = ch ? 8'h55 : 8'hAA;
        expq[i].push_back(e);
`endif
        dcyc = last + 1;
        doneq[i].push_back(dcyc);
        @(posedge clk); #1;
        drive(d, 1'b0, ch, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input int d, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (expq[2*d].size() == 0 && expq[2*d+1].size() == 0 &&
                doneq[2*d].size() == 0 && doneq[2*d+1].size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL wait_idle dut%0d timeout, pending beats %0d/%0d got ok=%b required 1",
                   d, expq[2*d].size(), expq[2*d+1].size(), ok);
        end
    endtask

    // Drop expectations later than cycle f (bursts aborted by flush/reset).
    task automatic purge(input int d, input int f);
        for (int j = 2 * d; j < 2 * d + 2; j++) begin
            while (expq[j].size() > 0 && expq[j][expq[j].size()-1].cyc > f)
                void'(expq[j].pop_back());
            while (doneq[j].size() > 0 && doneq[j][doneq[j].size()-1] > f)
                void'(doneq[j].pop_back());
        end
    endtask

    task automatic check_zero(input int d);
        for (int j = 2 * d; j < 2 * d + 2; j++) begin
            checks++;
            assert (mv[j] === 1'b0) else begin errors++; $error("FAIL rst_valid ch%0d got %b required 0", j, mv[j]); end
            checks++;
            assert (md[j] === 8'h00) else begin errors++; $error("FAIL rst_data ch%0d got %h required 00", j, md[j]); end
            checks++;
            assert (mb[j] === 1'b0) else begin errors++; $error("FAIL rst_busy ch%0d got %b required 0", j, mb[j]); end
            checks++;
            assert (mdn[j] === 1'b0) else begin errors++; $error("FAIL rst_done ch%0d got %b required 0", j, mdn[j]); end
        end
    endtask

    initial begin
        int dc, f, r;
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_zero(0);
        check_zero(1);
        checks++;
        assert (rdy(0) === 1'b1) else begin errors++; $error("FAIL rst_ready got %b required 1", rdy(0)); end
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Incrementing burst, GAP=0
        issue(0, 1'b0, 8'h10, 8'd3, 1'b1, dc);
        wait_idle(0, 50);

        // Incrementing burst with wrap, GAP=2, channel 2
        issue(1, 1'b1, 8'hFE, 8'd3, 1'b1, dc);
        wait_idle(1, 50);

        // 256-beat constant burst
        issue(0, 1'b0, 8'h5A, 8'd0, 1'b0, dc);
        repeat (100) begin @(posedge clk); #1; end
        checks++;
        assert (mb[0] === 1'b1) else begin errors++; $error("FAIL busy_long got %b required 1", mb[0]); end
        wait_idle(0, 400);

        // Command issued in the done cycle starts immediately after it
        issue(0, 1'b1, 8'h30, 8'd2, 1'b1, dc);
        while (cyc < dc) begin @(posedge clk); #1; end
        checks++;
        assert (mdn[1] === 1'b1) else begin errors++; $error("FAIL done_seen got %b required 1", mdn[1]); end
        issue(0, 1'b1, 8'h40, 8'd1, 1'b0, dc);
        wait_idle(0, 50);

        // Overlapping bursts on both channels
        issue(0, 1'b0, 8'h60, 8'd4, 1'b1, dc);
        issue(0, 1'b1, 8'h70, 8'd4, 1'b1, dc);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #1;
        checks++;
        assert (rdy(0) === 1'b0) else begin errors++; $error("FAIL ready_busy_ch0 got %b required 0", rdy(0)); end
        @(posedge clk); #1;
        wait_idle(0, 50);

        // flush together with a command for the idle channel
        issue(0, 1'b0, 8'h80, 8'd10, 1'b1, dc);
        repeat (3) begin @(posedge clk); #1; end
        f = cyc;
        drive(0, 1'b1, 1'b1, 8'h99, 8'd5, 1'b1, 1'b1);
        #1;
        checks++;
        assert (rdy(0) === 1'b0) else begin errors++; $error("FAIL ready_flush got %b required 0", rdy(0)); end
        purge(0, f);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        assert (mb[0] === 1'b0) else begin errors++; $error("FAIL flush_busy1 got %b required 0", mb[0]); end
        checks++;
        assert (mb[1] === 1'b0) else begin errors++; $error("FAIL flush_busy2 got %b required 0", mb[1]); end
        checks++;
        assert (mv[0] === 1'b0) else begin errors++; $error("FAIL flush_valid1 got %b required 0", mv[0]); end
        repeat (4) begin @(posedge clk); #1; end
        wait_idle(0, 10);

        // Asynchronous reset between edges during a burst
        issue(1, 1'b1, 8'hC0, 8'd8, 1'b1, dc);
        repeat (4) begin @(posedge clk); #1; end
        #2;
        reset_n = 1'b0;
        r = cyc;
        #1;
        check_zero(1);
        check_zero(0);
        purge(1, r - 1);
        purge(0, r - 1);
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        issue(1, 1'b1, 8'h21, 8'd2, 1'b1, dc);
        wait_idle(1, 50);

        for (int i = 0; i < 4; i++) begin
            checks++;
            assert (expq[i].size() === 0) else begin
                errors++; $error("FAIL leftover_beats ch%0d got %0d required 0", i, expq[i].size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_stream_tx.md
DUAL_STREAM_TX -- requirements
Module: dual_stream_tx

Interface
REQ-001 Parameter GAP, default 0: idle cycles (valid low) inserted between consecutive beats on a channel; legal range 0..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  selected channel can accept a command.
REQ-006 cmd_chan  input  1  target channel: 0 = channel 1, 1 = channel 2.
REQ-007 cmd_start  input  8  first data byte.
REQ-008 cmd_len  input  8  beat count; 0 encodes 256.
REQ-009 cmd_incr  input  1  1 = byte increments per beat, 0 = constant byte.
REQ-010 flush  input  1  synchronous abort of both channels.
REQ-011 valid1, valid2  output  1 each  beat strobe per channel; no backpressure.
REQ-012 in1, in2  output  8 each  beat data per channel.
REQ-013 busy1, busy2  output  1 each  channel engine not IDLE.
REQ-014 done1, done2  output  1 each  one-cycle burst-complete pulse.

Function
REQ-015 Each channel SHALL run an independent engine; both channels SHALL be able to emit beats in the same cycle.
REQ-016 cmd_ready SHALL be combinational: high when the engine selected by cmd_chan is IDLE and flush is low.
REQ-017 A command SHALL be accepted on a rising edge with cmd_valid && cmd_ready; the first beat SHALL appear in the following cycle.
REQ-018 Engine states: IDLE, SEND, GAP, MARK; IDLE->SEND on accept; SEND->GAP after a non-final beat when GAP>0, otherwise SEND->SEND; GAP->SEND after GAP cycles; after the final data beat -> MARK (macro on) or IDLE (macro off); MARK->IDLE after one beat.
REQ-019 valid SHALL be high only in SEND and MARK; in SHALL hold the last value while valid is low.
REQ-020 With cmd_incr = 1, beat n SHALL carry (cmd_start + n) mod 256; 8'hFF SHALL wrap to 8'h00.
REQ-021 Exactly cmd_len beats (256 for 0) SHALL be emitted before the optional marker.
REQ-022 done SHALL pulse high for one cycle, in the cycle after the last beat of the burst (marker included); busy SHALL be low in that cycle.
REQ-023 A command accepted in the done cycle SHALL produce its first beat in the next cycle (minimum one idle cycle between bursts).
REQ-024 flush SHALL force both engines to IDLE on the next edge, with valid low from that cycle onward and no done pulse; flush SHALL take priority over a simultaneous command.

Reset
REQ-025 reset_n low SHALL asynchronously force all engines to IDLE and valid1, valid2, in1, in2, busy1, busy2, done1, done2 to 0; a burst in progress SHALL be discarded.
REQ-026 The first command SHALL be accepted no earlier than the first rising edge after reset_n deasserts.

Configuration
REQ-027 With macro MARKER_INSERT_EN defined, each burst SHALL end with one extra marker beat (channel 1: 8'hAA, channel 2: 8'h55), placed GAP cycles after the final data beat.
REQ-028 Without MARKER_INSERT_EN, MARK state SHALL be absent and no marker beat SHALL be emitted.

Structure
REQ-029 Package dst_pkg SHALL hold the engine state enum, constants MARKER1 = 8'hAA and MARKER2 = 8'h55, and the GAP width.
REQ-030 Sub-module dst_chan_engine (one channel FSM, counter, data generator; marker value as a parameter) SHALL be instantiated twice.

Verification
REQ-031 GAP=0; chan 0, start 8'h10, len 3, incr 1 -> valid1 high 3 consecutive cycles carrying 10, 11, 12 (plus AA with macro), then done1 pulse.
REQ-032 GAP=2; chan 1, start 8'hFE, len 3, incr 1 -> in2 = FE, FF, 00, each beat separated by 2 valid-low cycles; 55 follows with macro.
REQ-033 len 0, incr 0, start 8'h5A -> 256 beats of 5A, then done; busy high for the entire burst.
REQ-034 Both channels commanded on consecutive cycles -> overlapping bursts; cmd_ready low for a busy channel only; beats land in the same cycles where expected.
REQ-035 flush asserted mid-burst together with cmd_valid -> valid1 and valid2 low from the next cycle, no done pulse, command not accepted.
REQ-036 reset_n pulsed low mid-burst, between edges -> all outputs 0 immediately; the next command after release starts from the new cmd_start.
